// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO fed by a valid/ready handshake,
// drained back-to-back onto a registered serial line at DELAY_FRAMES clocks per bit.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               busy,
  output logic               uart_tx
);

  localparam int CNT_W = $clog2(DELAY_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  txState_t           state;
  logic [7:0]         fifoMem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [FIFO_AW:0]   count;
  logic [CNT_W-1:0]   bitCnt;
  logic [2:0]         bitIdx;
  logic [7:0]         shiftReg;
  logic               txLine;
  logic               push;
  logic               pop;
  logic               bitEnd;
  logic               fifoEmpty;

  // Ready looks only at the count register, so a full FIFO never accepts on a popping edge.
  assign tx_ready   = (count != COUNT_FULL);
  assign fifoEmpty  = (count == '0);
  assign bitEnd     = (bitCnt == CNT_LAST);
  assign push       = tx_valid && tx_ready;
  assign pop        = !fifoEmpty && ((state == IDLE) || ((state == STOP) && bitEnd));
  assign fifo_count = count;
  assign busy       = (state != IDLE) || !fifoEmpty;
  assign uart_tx    = txLine;

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifoMem[wrPtr] <= tx_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A pop from IDLE or at the end of STOP loads the byte and drives the start bit on the same edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txLine   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txLine <= 1'b1;
          if (pop) begin
            shiftReg <= fifoMem[rdPtr];
            txLine   <= 1'b0;
            bitCnt   <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            bitCnt <= '0;
            bitIdx <= '0;
            txLine <= shiftReg[0];
            state  <= DATA;
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bitEnd) begin
            bitCnt <= '0;
            if (bitIdx == 3'd7) begin
              txLine <= 1'b1;
              state  <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              txLine <= shiftReg[bitIdx + 3'd1];
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bitEnd) begin
            bitCnt <= '0;
            if (pop) begin
              shiftReg <= fifoMem[rdPtr];
              txLine   <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        default: begin
          txLine <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: accepted bytes go into a scoreboard queue
// and a line monitor decodes each 8N1 frame and compares it against the queue head.
module tb_uart_tx_fifo;

  localparam int DF    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 10 * DF;

  logic          sys_clk;
  logic          sys_rst_n;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW:0]   fifo_count;
  logic          busy;
  logic          uart_tx;

  int            checks;
  int            failures;
  int            framesDone;
  int            sampleCnt;
  logic [7:0]    sbQ[$];
  int            frameStarts[$];
  int            lowRuns[$];

  uart_tx_fifo #(
    .DELAY_FRAMES(DF),
    .FIFO_DEPTH  (DEPTH),
    .FIFO_AW     (AW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .fifo_count(fifo_count),
    .busy      (busy),
    .uart_tx   (uart_tx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents one byte and holds it until an edge where tx_ready was high beforehand.
  task automatic applyStimulus(input logic [7:0] b);
    int   waited;
    logic readyNow;
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    forever begin
      readyNow = tx_ready;
      @(posedge sys_clk); #1;
      if (readyNow) break;
      waited++;
      if (waited > 2000) begin
        checkOutput("pushTimeout", 32'd0, 32'd1);
        break;
      end
    end
    if (readyNow) sbQ.push_back(b);
    tx_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int waited;
    waited = 0;
    while ((busy !== 1'b0) && (waited < budget)) begin
      @(posedge sys_clk); #1;
      waited++;
    end
    if (waited >= budget) checkOutput("drainTimeout", 32'(waited), 32'(budget - 1));
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  // Line monitor: a low sample starts a frame; the next 39 samples complete it.
  initial begin
    logic [FRAME-1:0] lv;
    logic [7:0]       rx;
    logic [7:0]       expByte;
    logic             aborted;
    logic             stable;
    logic             runDone;
    int               startIdx;
    int               lowRun;
    sampleCnt  = 0;
    framesDone = 0;
    forever begin
      @(negedge sys_clk);
      sampleCnt++;
      if ((sys_rst_n === 1'b1) && (uart_tx === 1'b0)) begin
        lv       = '0;
        startIdx = sampleCnt;
        aborted  = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge sys_clk);
          sampleCnt++;
          if (sys_rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          lv[i] = uart_tx;
        end
        if (!aborted) begin
          stable = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < DF; k++)
              if (lv[b*DF+k] !== lv[b*DF]) stable = 1'b0;
          for (int j = 0; j < 8; j++) rx[j] = lv[(j+1)*DF];
          lowRun  = 0;
          runDone = 1'b0;
          for (int i = 0; i < FRAME; i++) begin
            if (!runDone && lv[i] == 1'b0) lowRun++;
            else runDone = 1'b1;
          end
          frameStarts.push_back(startIdx);
          lowRuns.push_back(lowRun);
          framesDone++;
          checkOutput("bitTiming", {31'd0, stable}, 32'd1);
          checkOutput("stopBit", {31'd0, lv[9*DF]}, 32'd1);
          if (sbQ.size() == 0) begin
            checkOutput("unexpectedFrame", {24'd0, rx}, 32'hFFFF_FFFF);
          end else begin
            expByte = sbQ.pop_front();
            checkOutput("frameByte", {24'd0, rx}, {24'd0, expByte});
          end
        end
      end
    end
  end

  initial begin
    int waited;
    int lowSeen;
    int framesBefore;
    checks    = 0;
    failures  = 0;
    sys_rst_n = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("rstUartTx", {31'd0, uart_tx}, 32'd1);
    checkOutput("rstCount", {27'd0, fifo_count}, 32'd0);
    checkOutput("rstReady", {31'd0, tx_ready}, 32'd1);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    $display("[TB] single byte 0x55");
    applyStimulus(8'h55);
    checkOutput("t1CountAfterPush", {27'd0, fifo_count}, 32'd1);
    checkOutput("t1BusyAfterPush", {31'd0, busy}, 32'd1);
    checkOutput("t1LineIdle", {31'd0, uart_tx}, 32'd1);
    @(posedge sys_clk); #1;
    checkOutput("t1StartBit", {31'd0, uart_tx}, 32'd0);
    checkOutput("t1CountAfterPop", {27'd0, fifo_count}, 32'd0);
    repeat (FRAME - 1) @(posedge sys_clk);
    #1;
    checkOutput("t1BusyLastCycle", {31'd0, busy}, 32'd1);
    @(posedge sys_clk); #1;
    checkOutput("t1BusyFalls", {31'd0, busy}, 32'd0);
    checkOutput("t1LineHigh", {31'd0, uart_tx}, 32'd1);
    waitDrain(200);

    $display("[TB] back-to-back 0x48 0x69 0x0A");
    frameStarts.delete();
    applyStimulus(8'h48);
    checkOutput("t2Count0", {27'd0, fifo_count}, 32'd1);
    applyStimulus(8'h69);
    checkOutput("t2Count1", {27'd0, fifo_count}, 32'd1);
    applyStimulus(8'h0A);
    checkOutput("t2Count2", {27'd0, fifo_count}, 32'd2);
    waitDrain(400);
    checkOutput("t2FrameCount", 32'(frameStarts.size()), 32'd3);
    if (frameStarts.size() == 3) begin
      checkOutput("t2Gap01", 32'(frameStarts[1] - frameStarts[0]), 32'(FRAME));
      checkOutput("t2Gap12", 32'(frameStarts[2] - frameStarts[1]), 32'(FRAME));
    end

    $display("[TB] fill FIFO while transmitting");
    applyStimulus(8'hC0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'h10 + 8'(i));
    checkOutput("t3FullCount", {27'd0, fifo_count}, 32'd16);
    checkOutput("t3FullReady", {31'd0, tx_ready}, 32'd0);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    waited   = 0;
    while ((fifo_count == 5'd16) && (waited < 200)) begin
      @(posedge sys_clk); #1;
      waited++;
    end
    checkOutput("t3PopNoPush", {27'd0, fifo_count}, 32'd15);
    checkOutput("t3ReadyAgain", {31'd0, tx_ready}, 32'd1);
    @(posedge sys_clk); #1;
    checkOutput("t3LatePush", {27'd0, fifo_count}, 32'd16);
    sbQ.push_back(8'hEE);
    tx_valid = 1'b0;
    waitDrain(1500);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA3);
    applyStimulus(8'h31);
    applyStimulus(8'h32);
    applyStimulus(8'h33);
    checkOutput("t5Queued", {27'd0, fifo_count}, 32'd3);
    repeat (10) @(posedge sys_clk);
    #1;
    framesBefore = framesDone;
    sys_rst_n = 1'b0;
    tx_data   = 8'h77;
    tx_valid  = 1'b1;
    @(posedge sys_clk); #1;
    checkOutput("t5RstLine", {31'd0, uart_tx}, 32'd1);
    checkOutput("t5RstCount", {27'd0, fifo_count}, 32'd0);
    checkOutput("t5RstBusy", {31'd0, busy}, 32'd0);
    checkOutput("t5RstReady", {31'd0, tx_ready}, 32'd1);
    sbQ.delete();
    sys_rst_n = 1'b1;
    tx_valid  = 1'b0;
    lowSeen   = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge sys_clk); #1;
      if (uart_tx !== 1'b1) lowSeen++;
    end
    checkOutput("t5LineQuiet", 32'(lowSeen), 32'd0);
    checkOutput("t5NoFrames", 32'(framesDone), 32'(framesBefore));

    $display("[TB] all-zero and all-one bytes");
    lowRuns.delete();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    waitDrain(400);
    checkOutput("t6FrameCount", 32'(lowRuns.size()), 32'd2);
    if (lowRuns.size() == 2) begin
      checkOutput("t6ZeroLowRun", 32'(lowRuns[0]), 32'(9 * DF));
      checkOutput("t6OnesLowRun", 32'(lowRuns[1]), 32'(DF));
    end

    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
    checkOutput("totalFrames", 32'(framesDone), 32'd24);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
